// File: rtl/maze_pkg.sv
// maze_pkg: shared definitions for the depth-first maze solver.
//   - Direction codes used on move_dir and stored on the path stack.
//   - Solver state enumeration.
//   - opposite(): reverses a direction, used when backtracking.
package maze_pkg;

  localparam logic [1:0] DIR_RIGHT = 2'd0;  // X+1
  localparam logic [1:0] DIR_DOWN  = 2'd1;  // Y+1
  localparam logic [1:0] DIR_LEFT  = 2'd2;  // X-1
  localparam logic [1:0] DIR_UP    = 2'd3;  // Y-1

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_INIT_EVAL,
    S_MARK,
    S_PROBE,
    S_EVAL,
    S_BACK,
    S_OUT,
    S_DONE,
    S_FAIL
  } state_t;

  // Right<->left and down<->up differ only in bit 1.
  function automatic logic [1:0] opposite(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

endpackage

// File: rtl/maze_solver_path_stack.sv
// path_stack: LIFO of 2-bit moves, 2^(2N) deep.
//   clk, rst     : clock, synchronous active-high reset (empties the stack)
//   i_clr        : empty the stack (new search)
//   i_push       : write i_push_dir on top
//   i_pop        : drop the top entry (o_top_dir is the value being popped)
//   i_rd_idx     : indexed read address, o_rd_dir is the entry (bottom = 0)
//   o_empty, o_sp: occupancy
// Reads are combinational so the solver can pop and stream one entry per cycle.
module path_stack
  import maze_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_clr,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic [1:0]     i_push_dir,
  input  logic [2*N-1:0] i_rd_idx,
  output logic [1:0]     o_rd_dir,
  output logic [1:0]     o_top_dir,
  output logic           o_empty,
  output logic [2*N-1:0] o_sp
);
  localparam int SPW = 2 * N;
  localparam int DEPTH = 1 << SPW;
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  logic [1:0]     r_mem [DEPTH];
  logic [SPW-1:0] r_sp;

  // Storage has no reset; only the pointer defines what is valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_sp] <= i_push_dir;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_sp <= '0;
    end else if (i_push) begin
      r_sp <= r_sp + SP_ONE;
    end else if (i_pop) begin
      r_sp <= r_sp - SP_ONE;
    end
  end

  assign o_rd_dir  = r_mem[i_rd_idx];
  assign o_top_dir = r_mem[r_sp - SP_ONE];
  assign o_empty   = (r_sp == '0);
  assign o_sp      = r_sp;

endmodule

// File: rtl/maze_solver.sv
// maze_solver: depth-first search from (0,0) to (2^N-1,2^N-1) over an external
// 1-bit maze memory. Visited cells are written to 1. The found path is streamed
// bottom-first as 2-bit moves over move_valid/move_ready.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a search (IDLE/DONE/FAIL only)
//   X, Y, RD, WR, D_in  : memory address/strobes/write data (registered)
//   D_out               : memory read data, valid while RD is high
//   move_valid/dir/ready: path stream
//   done, fail          : search outcome, held until the next start
// Every output is a register loaded from the *next* state, so a strobe chosen in
// state S is on the memory pins during the following state (e.g. PROBE picks the
// neighbour, RD is high during EVAL, EVAL samples D_out).
module maze_solver
  import maze_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] X,
  output logic [N-1:0] Y,
  output logic         RD,
  output logic         WR,
  output logic         D_in,
  input  logic         D_out,
  output logic         move_valid,
  output logic [1:0]   move_dir,
  input  logic         move_ready,
  output logic         done,
  output logic         fail
);
  localparam int SPW = 2 * N;
  localparam logic [N-1:0]   C_MAX  = '1;
  localparam logic [N-1:0]   C_ONE  = N'(1);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_cx, r_cy, w_cx_next, w_cy_next;
  logic [1:0]     r_try, w_try_next;
  logic [SPW-1:0] r_rp, w_rp_next;
  logic [N-1:0]   r_x, r_y, w_x_next, w_y_next;
  logic           r_rd, r_wr, r_din, w_rd_next, w_wr_next;
  logic           r_move_valid, w_move_valid_next;
  logic [1:0]     r_move_dir, w_move_dir_next;
  logic           r_done, r_fail;

  logic           w_push, w_pop, w_clr, w_empty;
  logic [1:0]     w_rd_dir, w_top_dir;
  logic [SPW-1:0] w_sp, w_last, w_rd_idx;
  logic [N-1:0]   w_nx, w_ny, w_bx, w_by;
  logic           w_in_range, w_at_goal;

  path_stack #(.N(N)) u_stack (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_push_dir (r_try),
    .i_rd_idx   (w_rd_idx),
    .o_rd_dir   (w_rd_dir),
    .o_top_dir  (w_top_dir),
    .o_empty    (w_empty),
    .o_sp       (w_sp)
  );

  assign w_last    = w_sp - SP_ONE;
  assign w_at_goal = (r_cx == C_MAX) && (r_cy == C_MAX);
  // Look one entry ahead when the current one is being accepted, so move_dir
  // can be reloaded every cycle.
  assign w_rd_idx  = (r_state == S_OUT && move_ready) ? r_rp + SP_ONE : r_rp;

  // Neighbour of the current cell in direction r_try; no wrap-around.
  always_comb begin
    w_nx = r_cx;
    w_ny = r_cy;
    w_in_range = 1'b0;
    case (r_try)
      DIR_RIGHT: begin w_in_range = (r_cx != C_MAX); w_nx = r_cx + C_ONE; end
      DIR_DOWN:  begin w_in_range = (r_cy != C_MAX); w_ny = r_cy + C_ONE; end
      DIR_LEFT:  begin w_in_range = (r_cx != '0);    w_nx = r_cx - C_ONE; end
      default:   begin w_in_range = (r_cy != '0);    w_ny = r_cy - C_ONE; end
    endcase
  end

  // Parent cell when backtracking: undo the move on top of the stack.
  always_comb begin
    w_bx = r_cx;
    w_by = r_cy;
    case (opposite(w_top_dir))
      DIR_RIGHT: w_bx = r_cx + C_ONE;
      DIR_DOWN:  w_by = r_cy + C_ONE;
      DIR_LEFT:  w_bx = r_cx - C_ONE;
      default:   w_by = r_cy - C_ONE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cx         <= '0;
      r_cy         <= '0;
      r_try        <= '0;
      r_rp         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_din        <= 1'b0;
      r_move_valid <= 1'b0;
      r_move_dir   <= '0;
      r_done       <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cx         <= w_cx_next;
      r_cy         <= w_cy_next;
      r_try        <= w_try_next;
      r_rp         <= w_rp_next;
      r_x          <= w_x_next;
      r_y          <= w_y_next;
      r_rd         <= w_rd_next;
      r_wr         <= w_wr_next;
      r_din        <= 1'b1;
      r_move_valid <= w_move_valid_next;
      r_move_dir   <= w_move_dir_next;
      r_done       <= (w_state_next == S_DONE);
      r_fail       <= (w_state_next == S_FAIL);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: if (start) w_state_next = S_INIT;
      S_INIT:      w_state_next = S_INIT_EVAL;
      S_INIT_EVAL: w_state_next = D_out ? S_FAIL : S_MARK;
      S_MARK:      w_state_next = w_at_goal ? S_OUT : S_PROBE;
      S_PROBE: begin
        if (w_in_range)          w_state_next = S_EVAL;
        else if (r_try == 2'd3)  w_state_next = S_BACK;
      end
      S_EVAL: begin
        if (!D_out)              w_state_next = S_MARK;
        else if (r_try == 2'd3)  w_state_next = S_BACK;
        else                     w_state_next = S_PROBE;
      end
      // Popping an UP move leaves nothing to try at the parent: pop again.
      S_BACK: begin
        if (w_empty)                  w_state_next = S_FAIL;
        else if (w_top_dir != DIR_UP) w_state_next = S_PROBE;
      end
      S_OUT: if (move_ready && r_rp == w_last) w_state_next = S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath, stack control and next output values.
  always_comb begin
    w_cx_next         = r_cx;
    w_cy_next         = r_cy;
    w_try_next        = r_try;
    w_rp_next         = r_rp;
    w_x_next          = r_x;
    w_y_next          = r_y;
    w_rd_next         = 1'b0;
    w_wr_next         = 1'b0;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_clr             = 1'b0;
    w_move_valid_next = (w_state_next == S_OUT);
    w_move_dir_next   = (w_state_next == S_OUT) ? w_rd_dir : r_move_dir;
    case (r_state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          w_clr      = 1'b1;
          w_rp_next  = '0;
          w_try_next = '0;
          w_cx_next  = '0;
          w_cy_next  = '0;
        end
      end
      S_INIT: begin
        w_rd_next = 1'b1;
        w_x_next  = '0;
        w_y_next  = '0;
      end
      S_MARK: begin
        w_wr_next = 1'b1;
        w_x_next  = r_cx;
        w_y_next  = r_cy;
      end
      S_PROBE: begin
        if (w_in_range) begin
          w_rd_next = 1'b1;
          w_x_next  = w_nx;
          w_y_next  = w_ny;
        end else if (r_try != 2'd3) begin
          w_try_next = r_try + 2'd1;
        end
      end
      S_EVAL: begin
        if (!D_out) begin
          w_push     = 1'b1;
          w_cx_next  = w_nx;
          w_cy_next  = w_ny;
          w_try_next = '0;
        end else if (r_try != 2'd3) begin
          w_try_next = r_try + 2'd1;
        end
      end
      S_BACK: begin
        if (!w_empty) begin
          w_pop      = 1'b1;
          w_cx_next  = w_bx;
          w_cy_next  = w_by;
          w_try_next = w_top_dir + 2'd1;
        end
      end
      S_OUT: begin
        if (move_ready && r_rp != w_last) w_rp_next = r_rp + SP_ONE;
      end
      default: ;
    endcase
  end

  assign X          = r_x;
  assign Y          = r_y;
  assign RD         = r_rd;
  assign WR         = r_wr;
  assign D_in       = r_din;
  assign move_valid = r_move_valid;
  assign move_dir   = r_move_dir;
  assign done       = r_done;
  assign fail       = r_fail;

endmodule

// File: tb/tb_maze_solver.sv
// Directed bench for maze_solver (N=4, 16x16) with a behavioural maze memory.
module tb_maze_solver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] X, Y;
  logic       RD, WR, D_in, D_out;
  logic       move_valid;
  logic [1:0] move_dir;
  logic       move_ready = 1'b1;
  logic       done, fail;

  logic       mem  [16][16];  // [y][x]
  logic       orig [16][16];  // image loaded into mem
  logic       load_en = 1'b0;
  int         wr_cnt = 0;
  int         both_cnt = 0;
  logic [1:0] moves [$];
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  maze_solver #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .X          (X),
    .Y          (Y),
    .RD         (RD),
    .WR         (WR),
    .D_in       (D_in),
    .D_out      (D_out),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .done       (done),
    .fail       (fail)
  );

  assign D_out = mem[Y][X];

  always @(posedge clk) begin
    if (load_en) mem <= orig;
    else if (WR) mem[Y][X] <= D_in;
    if (WR) wr_cnt <= wr_cnt + 1;
    if (RD && WR) both_cnt <= both_cnt + 1;
  end

  task automatic fill(input logic v);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        orig[y][x] = v;
  endtask

  task automatic do_load();
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Runs until done/fail or budget. mode 0: ready=1; mode 1: ready 1,0,0,1 repeating.
  task automatic run_collect(input int mode, input int budget, input int poke_at,
                             output logic got_done, output logic got_fail,
                             output logic saw_valid, output int stall_errs);
    logic       pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       stalled = 1'b0;
    logic [1:0] prev_dir = 2'd0;
    moves.delete();
    got_done = 1'b0; got_fail = 1'b0; saw_valid = 1'b0; stall_errs = 0;
    pulse_start();
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin got_done = 1'b1; break; end
      if (fail) begin got_fail = 1'b1; break; end
      if (stalled && (!move_valid || move_dir !== prev_dir)) stall_errs++;
      move_ready = (mode == 0) ? 1'b1 : pat[c % 4];
      if (move_valid) saw_valid = 1'b1;
      if (move_valid && move_ready) moves.push_back(move_dir);
      stalled  = move_valid && !move_ready;
      prev_dir = move_dir;
      if (c == poke_at) start = 1'b1;
    end
    start = 1'b0;
    move_ready = 1'b1;
  endtask

  // Expected path on an open maze: 15 rights then 15 downs.
  task automatic check_open_path(input string tag);
    n_tests++;
    if (moves.size() !== 30) begin
      n_fail++;
      $display("FAIL %s_len: got %0d moves, expected 30", tag, moves.size());
    end else begin
      for (int i = 0; i < 30; i++) begin
        n_tests++;
        if (moves[i] !== ((i < 15) ? 2'd0 : 2'd1)) begin
          n_fail++;
          $display("FAIL %s_move[%0d]: got %0d, expected %0d", tag, i, moves[i],
                   (i < 15) ? 0 : 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {X, Y, RD, WR, D_in, move_valid, move_dir, done, fail};
    n_tests++;
    if (obs !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, expected 0000", obs);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_open_maze();
    logic d, f, v; int se; int both0;
    both0 = both_cnt;
    fill(1'b0); do_load();
    run_collect(0, 2000, -1, d, f, v, se);
    n_tests++;
    if (d !== 1'b1 || f !== 1'b0) begin
      n_fail++;
      $display("FAIL open_done: done=%b fail=%b, expected done=1 fail=0", d, f);
    end
    check_open_path("open");
    n_tests++;
    if (both_cnt - both0 !== 0) begin
      n_fail++;
      $display("FAIL open_rd_wr_overlap: %0d cycles, expected 0", both_cnt - both0);
    end
  endtask

  task automatic test_start_blocked();
    int wr0;
    fill(1'b0); orig[0][0] = 1'b1; do_load();
    wr0 = wr_cnt;
    pulse_start();
    @(posedge clk); #1;
    n_tests++;
    if (fail !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL blocked_early: fail=%b done=%b, expected 0 0", fail, done);
    end
    @(posedge clk); #1;
    n_tests++;
    if (fail !== 1'b1) begin
      n_fail++;
      $display("FAIL blocked_fail: fail=%b, expected 1", fail);
    end
    repeat (4) @(posedge clk);
    #1;
    n_tests++;
    if (wr_cnt - wr0 !== 0 || fail !== 1'b1) begin
      n_fail++;
      $display("FAIL blocked_nowrite: writes=%0d fail=%b, expected 0 writes fail=1",
               wr_cnt - wr0, fail);
    end
  endtask

  task automatic test_backtrack();
    logic d, f, v; int se; int px, py, bad;
    fill(1'b1);
    for (int x = 0; x < 3; x++) orig[0][x] = 1'b0;
    for (int y = 0; y < 16; y++) orig[y][2] = 1'b0;
    for (int x = 2; x < 16; x++) orig[15][x] = 1'b0;
    orig[1][3] = 1'b0; orig[1][4] = 1'b0;  // dead-end branch
    do_load();
    run_collect(0, 4000, -1, d, f, v, se);
    n_tests++;
    if (d !== 1'b1 || moves.size() !== 30) begin
      n_fail++;
      $display("FAIL bt_done: done=%b len=%0d, expected done=1 len=30", d, moves.size());
    end
    px = 0; py = 0; bad = (mem[0][0] !== 1'b1) ? 1 : 0;
    foreach (moves[i]) begin
      case (moves[i])
        2'd0: px++;
        2'd1: py++;
        2'd2: px--;
        default: py--;
      endcase
      if (px < 0 || px > 15 || py < 0 || py > 15) begin bad++; break; end
      if (orig[py][px] !== 1'b0 || mem[py][px] !== 1'b1) bad++;
    end
    n_tests++;
    if (bad !== 0 || px !== 15 || py !== 15) begin
      n_fail++;
      $display("FAIL bt_path: bad=%0d end=(%0d,%0d), expected bad=0 end=(15,15)", bad, px, py);
    end
    n_tests++;
    if (mem[1][3] !== 1'b1 || mem[1][4] !== 1'b1) begin
      n_fail++;
      $display("FAIL bt_deadend_marked: (3,1)=%b (4,1)=%b, expected 1 1", mem[1][3], mem[1][4]);
    end
  endtask

  task automatic test_enclosed_goal();
    logic d, f, v; int se; int ones;
    fill(1'b0); orig[15][14] = 1'b1; orig[14][15] = 1'b1; do_load();
    run_collect(0, 20000, -1, d, f, v, se);
    n_tests++;
    if (f !== 1'b1 || d !== 1'b0) begin
      n_fail++;
      $display("FAIL encl_fail: fail=%b done=%b, expected fail=1 done=0", f, d);
    end
    n_tests++;
    if (v !== 1'b0) begin
      n_fail++;
      $display("FAIL encl_no_valid: move_valid seen=%b, expected 0", v);
    end
    ones = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        if (mem[y][x] === 1'b1) ones++;
    n_tests++;
    if (ones !== 255 || mem[15][15] !== 1'b0) begin
      n_fail++;
      $display("FAIL encl_marks: ones=%0d goal=%b, expected 255 and 0", ones, mem[15][15]);
    end
  endtask

  task automatic test_backpressure();
    logic d, f, v; int se;
    fill(1'b0); do_load();
    // A start pulse mid-search must be ignored.
    run_collect(1, 3000, 40, d, f, v, se);
    n_tests++;
    if (d !== 1'b1 || se !== 0) begin
      n_fail++;
      $display("FAIL bp_stall: done=%b stall_errors=%0d, expected done=1 errors=0", d, se);
    end
    check_open_path("bp");
  endtask

  task automatic test_reset_mid_search();
    logic [15:0] obs; logic d, f, v; int se; int wr0;
    fill(1'b0); do_load();
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    obs = {X, Y, RD, WR, D_in, move_valid, move_dir, done, fail};
    n_tests++;
    if (obs !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got %h, expected 0000", obs);
    end
    wr0 = wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (wr_cnt - wr0 !== 0 || move_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: writes=%0d valid=%b, expected 0 0", wr_cnt - wr0, move_valid);
    end
    do_load();
    run_collect(0, 2000, -1, d, f, v, se);
    n_tests++;
    if (d !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_rerun_done: done=%b, expected 1", d);
    end
    check_open_path("midrst");
  endtask

  initial begin
    fill(1'b0);
    test_reset();
    test_open_maze();
    test_start_blocked();
    test_backtrack();
    test_enclosed_goal();
    test_backpressure();
    test_reset_mid_search();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
